// File: rtl/ps2_pkg.sv
// Shared PS/2 link types and helpers, used by the host transmitter and the scan-code receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    STOP,
    RELEASE
  } ps2_tx_state_t;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned PS2_ACK_EDGE  = 11;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus a registered falling-edge pulse.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, fall_q;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_command_transmitter.sv
// Host-to-device PS/2 command sender. Drives the pads only through open-drain enables;
// the tri-state buffers live in the CLOCK_50-domain wrapper.
module ps2_command_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_dat_in,
  output logic                     ps2_clk_oe,
  output logic                     ps2_dat_oe,
  input  logic [PS2_DATA_BITS-1:0] i_command,
  input  logic                     i_send,
  output logic                     o_busy,
  output logic                     o_sent,
  output logic                     o_error
);

  localparam int unsigned CntMax   = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                       : INHIBIT_CYCLES;
  localparam int unsigned CntW     = $clog2(CntMax) + 1;
  localparam int unsigned ShW      = PS2_DATA_BITS + 1;
  localparam int unsigned StopEdge = PS2_ACK_EDGE - 1;

  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  logic clk_sync, clk_fall, dat_sync, unused_dat_fall;

  ps2_line_sync u_clk_sync (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .line_i (ps2_clk_in),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .line_i (ps2_dat_in),
    .sync_o (dat_sync),
    .fall_o (unused_dat_fall)
  );

  ps2_tx_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [ShW-1:0]  sh_q, sh_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            busy_q, busy_d;
  logic            sent_q, sent_d;
  logic            error_q, error_d;
  logic            timeout;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    dat_oe_d = dat_oe_q;
    sent_d   = 1'b0;
    error_d  = 1'b0;
    timeout  = 1'b0;

    // Device-clocked phases: the counter measures the gap since the last falling edge.
    if (state_q inside {REQ, SHIFT, STOP, RELEASE}) begin
      if (clk_fall) begin
        cnt_d = '0;
      end else if (cnt_q == TimeoutLast) begin
        timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_send) begin
          state_d = INHIBIT;
          sh_d    = {ps2_odd_parity(i_command), i_command};
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      INHIBIT: begin
        if (cnt_q == InhibitLast) begin
          state_d  = REQ;
          cnt_d    = '0;
          dat_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        if (clk_fall) begin
          state_d  = SHIFT;
          dat_oe_d = ~sh_q[0];
          sh_d     = sh_q >> 1;
          idx_d    = 4'd1;
        end
      end
      SHIFT: begin
        // idx_q counts falling edges seen so far; the next one after parity is the stop edge.
        if (clk_fall) begin
          if (idx_q == 4'(StopEdge - 1)) begin
            state_d  = STOP;
            dat_oe_d = 1'b0;
          end else begin
            dat_oe_d = ~sh_q[0];
            sh_d     = sh_q >> 1;
            idx_d    = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (clk_fall) begin
          if (!dat_sync) begin
            state_d = RELEASE;
          end else begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (clk_sync && dat_sync) begin
          state_d = IDLE;
          sent_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout && state_d != IDLE) begin
      state_d = IDLE;
      error_d = 1'b1;
    end

    if (state_d == IDLE) begin
      dat_oe_d = 1'b0;
      cnt_d    = '0;
      idx_d    = '0;
    end

    clk_oe_d = (state_d == INHIBIT);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      sent_q   <= sent_d;
      error_q  <= error_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign o_busy     = busy_q;
  assign o_sent     = sent_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_ps2_command_transmitter.sv
// Bench for the PS/2 command transmitter: open-drain pad model, clocking device model and
// a frame-level reference model built from the protocol rules.
module tb_ps2_command_transmitter;

  localparam int unsigned Inh = 50;
  localparam int unsigned To  = 300;
  localparam int unsigned Hp  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] i_command = 8'h00;
  logic       i_send = 1'b0;
  logic       ps2_clk_oe, ps2_dat_oe, o_busy, o_sent, o_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_pad, dat_pad;

  assign clk_pad = ~(ps2_clk_oe | dev_clk_low);
  assign dat_pad = ~(ps2_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_command_transmitter #(
    .INHIBIT_CYCLES (Inh),
    .TIMEOUT_CYCLES (To)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .ps2_clk_in (clk_pad),
    .ps2_dat_in (dat_pad),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .i_command  (i_command),
    .i_send     (i_send),
    .o_busy     (o_busy),
    .o_sent     (o_sent),
    .o_error    (o_error)
  );

  int n_checks = 0;
  int n_errors = 0;
  int sent_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [1:0] err_oe = 2'b00;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_sent) sent_cnt++;
      if (o_error) begin
        err_cnt++;
        err_oe = {ps2_clk_oe, ps2_dat_oe};
      end
      if (o_sent && o_error) both_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame as the device sees it: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] c);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = c[i];
      ones += int'(c[i]);
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_send(input logic [7:0] cmd);
    @(negedge clk);
    i_command = cmd;
    i_send    = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    check_eq("busy_rise", o_busy, 1);
  endtask

  // Returns on the first cycle with clk_oe released.
  task automatic measure_inhibit(output int len);
    len = 0;
    while (ps2_clk_oe === 1'b1 && len < Inh + 20) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic dev_clock(output logic sample);
    dev_clk_low = 1'b1;
    repeat (Hp) @(negedge clk);
    dev_clk_low = 1'b0;
    sample = dat_pad;
    repeat (Hp) @(negedge clk);
  endtask

  task automatic device_frame(input bit ack, output logic [10:0] seen);
    logic b;
    repeat (4) @(negedge clk);
    seen[0] = dat_pad;
    for (int k = 1; k <= 10; k++) begin
      dev_clock(b);
      seen[k] = b;
    end
    if (ack) dev_dat_low = 1'b1;
    dev_clock(b);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check_eq("idle", o_busy, 0);
  endtask

  task automatic run_tx(input logic [7:0] cmd, input bit ack, input bit poke);
    int s0, e0, inh;
    logic [10:0] seen;
    s0 = sent_cnt;
    e0 = err_cnt;
    start_send(cmd);
    measure_inhibit(inh);
    check_eq("inhibit_len", inh, Inh);
    check_eq("dat_oe_at_req", ps2_dat_oe, 1);
    if (poke) begin
      i_command = ~cmd;
      i_send    = 1'b1;
      @(negedge clk);
      i_send = 1'b0;
    end
    device_frame(ack, seen);
    check_eq("frame", seen, ref_frame(cmd));
    wait_idle();
    check_eq("sent_pulses", sent_cnt - s0, ack ? 1 : 0);
    check_eq("err_pulses", err_cnt - e0, ack ? 0 : 1);
    if (!ack) check_eq("oe_at_err", err_oe, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, e0, inh, n;
    logic b;

    repeat (3) @(negedge clk);
    check_eq("rst_clk_oe", ps2_clk_oe, 0);
    check_eq("rst_dat_oe", ps2_dat_oe, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_sent", o_sent, 0);
    check_eq("rst_error", o_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_tx(8'hED, 1'b1, 1'b0);
    run_tx(8'h07, 1'b1, 1'b0);
    run_tx(8'h00, 1'b1, 1'b0);
    run_tx(8'hA3, 1'b0, 1'b0);
    run_tx(8'h5C, 1'b1, 1'b1);
    for (int t = 0; t < 6; t++) begin
      run_tx(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
    end

    // Device never clocks; a second send during the wait must be ignored.
    s0 = sent_cnt;
    e0 = err_cnt;
    start_send(8'h5A);
    measure_inhibit(inh);
    n = 0;
    while (!o_error && n < To + 50) begin
      if (n == 10) begin
        i_command = 8'hA5;
        i_send    = 1'b1;
      end else begin
        i_send = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    i_send = 1'b0;
    check_eq("timeout_cycles", n, To);
    check_eq("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    wait_idle();
    check_eq("timeout_err", err_cnt - e0, 1);
    check_eq("timeout_sent", sent_cnt - s0, 0);

    // Asynchronous reset during INHIBIT.
    start_send(8'h33);
    repeat (5) @(negedge clk);
    check_eq("pre_rst_clk_oe", ps2_clk_oe, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_eq("async_rst_clk_oe", ps2_clk_oe, 0);
    check_eq("async_rst_busy", o_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset at bit 4 of an all-zero byte (data line held low).
    start_send(8'h00);
    measure_inhibit(inh);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) dev_clock(b);
    check_eq("pre_rst_dat_oe", ps2_dat_oe, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_eq("bit4_rst_oes", {ps2_clk_oe, ps2_dat_oe}, 0);
    check_eq("bit4_rst_busy", o_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_tx(8'hFF, 1'b1, 1'b0);

    check_eq("sent_and_error_same_cycle", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
